// File: rtl/riscv_mc_controller.sv
// riscv_mc_controller: multicycle RISC-V Moore FSM driving datapath selects, enables and ALU control.
module riscv_mc_controller (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       zero,
  input  logic       notZero,
  input  logic       LessThan,
  input  logic       GreaterEqual,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ImmSrc,
  output logic [2:0] alucontrol
);
  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE,
    EXECUTER, EXECUTEI, ALUWB, BRANCH, JAL
  } state_t;
  state_t state, next;
  logic [1:0] aluop;
  logic pcupdate, branch, taken;
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= FETCH;
    else state <= next;
  always_comb begin
    next = FETCH;
    AdrSrc = 1'b0;
    MemWrite = 1'b0;
    IRWrite = 1'b0;
    RegWrite = 1'b0;
    ResultSrc = 2'b00;
    ALUSrcA = 2'b00;
    ALUSrcB = 2'b00;
    aluop = 2'b00;
    pcupdate = 1'b0;
    branch = 1'b0;
    case (state)
      FETCH: begin
        IRWrite = 1'b1;
        ALUSrcB = 2'b10;
        ResultSrc = 2'b10;
        pcupdate = 1'b1;
        next = DECODE;
      end
      DECODE: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
        next = (op == 7'b0000011 || op == 7'b0100011) ? MEMADR :
               (op == 7'b0110011) ? EXECUTER :
               (op == 7'b0010011) ? EXECUTEI :
               (op == 7'b1100011) ? BRANCH :
               (op == 7'b1101111) ? JAL : FETCH;
      end
      MEMADR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        next = (op == 7'b0000011) ? MEMREAD : MEMWRITE;
      end
      MEMREAD: begin
        AdrSrc = 1'b1;
        next = MEMWB;
      end
      MEMWB: begin
        ResultSrc = 2'b01;
        RegWrite = 1'b1;
      end
      MEMWRITE: begin
        AdrSrc = 1'b1;
        MemWrite = 1'b1;
      end
      EXECUTER: begin
        ALUSrcA = 2'b10;
        aluop = 2'b10;
        next = ALUWB;
      end
      EXECUTEI: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        aluop = 2'b10;
        next = ALUWB;
      end
      ALUWB: RegWrite = 1'b1;
      BRANCH: begin
        ALUSrcA = 2'b10;
        aluop = 2'b01;
        branch = 1'b1;
      end
      JAL: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b10;
        pcupdate = 1'b1;
        next = ALUWB;
      end
      default: next = FETCH;
    endcase
  end
  always_comb begin
    taken = (funct3 == 3'b000) ? zero :
            (funct3 == 3'b001) ? notZero :
            (funct3 == 3'b100) ? LessThan :
            (funct3 == 3'b101) ? GreaterEqual : 1'b0;
    PCWrite = pcupdate | (branch & taken);
    ImmSrc = (op == 7'b0100011) ? 2'b01 :
             (op == 7'b1100011) ? 2'b10 :
             (op == 7'b1101111) ? 2'b11 : 2'b00;
  end
  // Only the ALU-decode ALUOp looks at funct3; shifts right are always logical.
  always_comb begin
    alucontrol = 3'b000;
    if (aluop == 2'b01) alucontrol = 3'b001;
    else if (aluop == 2'b10)
      case (funct3)
        3'b000:  alucontrol = (op[5] & funct7b5) ? 3'b001 : 3'b000;
        3'b001:  alucontrol = 3'b100;
        3'b010:  alucontrol = 3'b101;
        3'b100:  alucontrol = 3'b111;
        3'b101:  alucontrol = 3'b110;
        3'b110:  alucontrol = 3'b011;
        3'b111:  alucontrol = 3'b010;
        default: alucontrol = 3'b000;
      endcase
  end
endmodule

// File: tb/tb_riscv_mc_controller.sv
// tb_riscv_mc_controller: directed scoreboard bench for the multicycle controller.
module tb_riscv_mc_controller;
  logic clk = 1'b0, reset = 1'b1;
  logic [6:0] op = 7'd0;
  logic [2:0] funct3 = 3'd0;
  logic funct7b5 = 1'b0, zero = 1'b0, notZero = 1'b0, LessThan = 1'b0, GreaterEqual = 1'b0;
  logic PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
  logic [2:0] alucontrol;
  logic [15:0] obs;
  logic [15:0] eq[$], mq[$];
  string tq[$];
  int total = 0, passed = 0;

  riscv_mc_controller dut (
    .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5),
    .zero(zero), .notZero(notZero), .LessThan(LessThan), .GreaterEqual(GreaterEqual),
    .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .RegWrite(RegWrite), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ImmSrc(ImmSrc), .alucontrol(alucontrol)
  );

  always #5 clk = ~clk;
  assign obs = {PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, alucontrol};

  function automatic logic [15:0] o(input logic pcw, adr, mw, irw, rw,
                                    input logic [1:0] rs, sa, sb, imm, input logic [2:0] alu);
    return {pcw, adr, mw, irw, rw, rs, sa, sb, imm, alu};
  endfunction
  function automatic logic [15:0] s_fetch(input logic [1:0] i);
    return o(1, 0, 0, 1, 0, 2'b10, 2'b00, 2'b10, i, 3'b000);
  endfunction
  function automatic logic [15:0] s_decode(input logic [1:0] i);
    return o(0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, i, 3'b000);
  endfunction
  function automatic logic [15:0] s_aluwb(input logic [1:0] i);
    return o(0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, i, 3'b000);
  endfunction
  function automatic logic [15:0] s_branch(input logic t);
    return o(t, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b10, 3'b001);
  endfunction

  task automatic push(input string t, input logic [15:0] e, input logic [15:0] m = 16'hffff);
    tq.push_back(t);
    eq.push_back(e);
    mq.push_back(m);
  endtask

  task automatic cmp();
    logic [15:0] e, m;
    string t;
    #1;
    total++;
    if (eq.size() == 0) begin
      $error("FAIL scoreboard_empty obs=%h exp=none", obs);
      return;
    end
    t = tq.pop_front();
    e = eq.pop_front();
    m = mq.pop_front();
    assert ((obs & m) === (e & m)) passed++;
    else $error("FAIL %s obs=%h exp=%h", t, obs & m, e & m);
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) begin
      cmp();
      @(negedge clk);
    end
  endtask

  task automatic set_in(input logic [6:0] o_, input logic [2:0] f3, input logic f7,
                        input logic z, nz, lt, ge);
    op = o_; funct3 = f3; funct7b5 = f7;
    zero = z; notZero = nz; LessThan = lt; GreaterEqual = ge;
  endtask

  task automatic rtype(input string t, input logic [6:0] o_, input logic [2:0] f3,
                       input logic f7, input logic [2:0] alu);
    set_in(o_, f3, f7, 0, 1, 0, 1);
    push({t, "_fetch"}, s_fetch(2'b00));
    push({t, "_decode"}, s_decode(2'b00));
    push({t, "_exec"}, o(0, 0, 0, 0, 0, 2'b00, 2'b10, (o_ == 7'b0010011) ? 2'b01 : 2'b00, 2'b00, alu));
    push({t, "_aluwb"}, s_aluwb(2'b00));
    run(4);
  endtask

  task automatic br(input string t, input logic [2:0] f3, input logic z, nz, lt, ge, input logic tk);
    set_in(7'b1100011, f3, 0, z, nz, lt, ge);
    push({t, "_fetch"}, s_fetch(2'b10));
    push({t, "_decode"}, s_decode(2'b10));
    push({t, "_branch"}, s_branch(tk));
    run(3);
  endtask

  initial begin
    @(negedge clk);
    push("in_reset", s_fetch(2'b00));
    cmp();
    @(negedge clk);
    reset = 1'b0;
    // lw interrupted by reset in MEMREAD, then rerun from DECODE
    set_in(7'b0000011, 3'b010, 0, 0, 1, 0, 1);
    push("lw_fetch", s_fetch(2'b00));
    push("lw_decode", s_decode(2'b00));
    push("lw_memadr", o(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b00, 3'b000));
    push("lw_memread", o(0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000));
    run(3);
    cmp();
    reset = 1'b1;
    push("rst_async", s_fetch(2'b00));
    cmp();
    @(negedge clk);
    push("rst_hold", s_fetch(2'b00));
    cmp();
    reset = 1'b0;
    @(negedge clk);
    push("rst_then_decode", s_decode(2'b00));
    cmp();
    @(negedge clk);
    push("lw_memadr2", o(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b00, 3'b000));
    push("lw_memread2", o(0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000));
    push("lw_memwb", o(0, 0, 0, 0, 1, 2'b01, 2'b00, 2'b00, 2'b00, 3'b000), 16'hbfff);
    run(3);
    set_in(7'b0100011, 3'b010, 0, 0, 1, 0, 1);
    push("sw_fetch", s_fetch(2'b01));
    push("sw_decode", s_decode(2'b01));
    push("sw_memadr", o(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b01, 3'b000));
    push("sw_memwrite", o(0, 1, 1, 0, 0, 2'b00, 2'b00, 2'b00, 2'b01, 3'b000));
    run(4);
    rtype("sub", 7'b0110011, 3'b000, 1, 3'b001);
    rtype("addi", 7'b0010011, 3'b000, 1, 3'b000);
    rtype("srl", 7'b0110011, 3'b101, 1, 3'b110);
    rtype("and", 7'b0110011, 3'b111, 0, 3'b010);
    rtype("slt", 7'b0110011, 3'b010, 0, 3'b101);
    rtype("xori", 7'b0010011, 3'b100, 0, 3'b111);
    br("beq_t", 3'b000, 1, 0, 0, 1, 1);
    br("beq_nt", 3'b000, 0, 1, 1, 0, 0);
    br("bne_nt", 3'b001, 1, 0, 0, 1, 0);
    br("blt_t", 3'b100, 0, 1, 1, 0, 1);
    br("bge_nt", 3'b101, 0, 1, 1, 0, 0);
    br("bge_t", 3'b101, 0, 1, 0, 1, 1);
    br("f3_110", 3'b110, 1, 1, 1, 1, 0);
    set_in(7'b1101111, 3'b000, 0, 0, 1, 0, 1);
    push("jal_fetch", s_fetch(2'b11));
    push("jal_decode", s_decode(2'b11));
    push("jal_jal", o(1, 0, 0, 0, 0, 2'b00, 2'b01, 2'b10, 2'b11, 3'b000));
    push("jal_aluwb", s_aluwb(2'b11));
    run(4);
    set_in(7'b1111111, 3'b000, 0, 1, 0, 0, 1);
    push("ill_fetch", s_fetch(2'b00));
    push("ill_decode", s_decode(2'b00));
    push("ill_refetch", s_fetch(2'b00));
    push("ill_redecode", s_decode(2'b00));
    run(4);
    total++;
    assert (eq.size() == 0) passed++;
    else $error("FAIL scoreboard_leftover obs=%0d exp=0", eq.size());
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
